// File: rtl/mult_iter_param.sv
// mult_iter_param: iterative RISC-V M-extension multiplier (MUL/MULH/MULHSU/MULHU), BITS_PER_CYCLE bits per cycle.
// Define MULT_FUSE_EN to add a product cache so an op that repeats the last operands skips CALC/FIX.
module mult_iter_param #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 4,
  parameter int TAG_W          = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [1:0]       op_i,
  input  logic [XLEN-1:0]  operand_a_i,
  input  logic [XLEN-1:0]  operand_b_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  result_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             busy_o
);

  localparam int BPC   = BITS_PER_CYCLE;
  localparam int ITER  = XLEN / BPC;
  localparam int SW    = XLEN + BPC + 1;
  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN:0]     aExt_q, aExt_d;
  logic [XLEN:0]     hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic              bNeg_q, bNeg_d;
  logic [1:0]        op_q, op_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [XLEN-1:0]   result_q, result_d;

`ifdef MULT_FUSE_EN
  logic [XLEN-1:0]   opB_q, opB_d;
  logic              sa_q, sa_d;
  logic              sb_q, sb_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic              cacheValid_q, cacheValid_d;
  logic [XLEN-1:0]   cacheA_q, cacheA_d;
  logic [XLEN-1:0]   cacheB_q, cacheB_d;
  logic              cacheSa_q, cacheSa_d;
  logic              cacheSb_q, cacheSb_d;
  logic [2*XLEN-1:0] cacheProd_q, cacheProd_d;
  logic              cacheHit;
`endif

  logic              signA, signB;
  logic [BPC-1:0]    digit;
  logic [SW-1:0]     aWide, hiWide, digitWide, stepSum;
  logic [XLEN-1:0]   hiFix;
  logic [2*XLEN-1:0] product;
  logic [XLEN-1:0]   selected;

  assign signA = (op_i == 2'b01) || (op_i == 2'b10);
  assign signB = (op_i == 2'b01);

  // Shift-add step: hi holds the running partial product above the bits already shifted into lo.
  assign digit     = lo_q[BPC-1:0];
  assign aWide     = {{BPC{aExt_q[XLEN]}}, aExt_q};
  assign hiWide    = {{BPC{hi_q[XLEN]}}, hi_q};
  assign digitWide = {{(XLEN+1){1'b0}}, digit};
  assign stepSum   = hiWide + aWide * digitWide;

  // Only XLEN bits of b are consumed in CALC; a negative signed b needs a*2^XLEN removed.
  assign hiFix    = hi_q[XLEN-1:0] - (bNeg_q ? aExt_q[XLEN-1:0] : {XLEN{1'b0}});
  assign product  = {hiFix, lo_q};
  assign selected = (op_q == OP_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];

`ifdef MULT_FUSE_EN
  assign cacheHit = cacheValid_q && (operand_a_i == cacheA_q) && (operand_b_i == cacheB_q) &&
                    ((op_i == OP_MUL) || ({signA, signB} == {cacheSa_q, cacheSb_q}));
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    aExt_d   = aExt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    bNeg_d   = bNeg_q;
    op_d     = op_q;
    tag_d    = tag_q;
    result_d = result_q;
`ifdef MULT_FUSE_EN
    opB_d        = opB_q;
    sa_d         = sa_q;
    sb_d         = sb_q;
    prod_d       = prod_q;
    cacheValid_d = cacheValid_q;
    cacheA_d     = cacheA_q;
    cacheB_d     = cacheB_q;
    cacheSa_d    = cacheSa_q;
    cacheSb_d    = cacheSb_q;
    cacheProd_d  = cacheProd_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          aExt_d  = {signA & operand_a_i[XLEN-1], operand_a_i};
          bNeg_d  = signB & operand_b_i[XLEN-1];
          op_d    = op_i;
          tag_d   = tag_i;
          cnt_d   = '0;
          hi_d    = '0;
          lo_d    = operand_b_i;
          state_d = S_CALC;
`ifdef MULT_FUSE_EN
          opB_d = operand_b_i;
          sa_d  = signA;
          sb_d  = signB;
          // A hit keeps the cached signedness so the re-stored entry still describes its product.
          if (cacheHit) begin
            sa_d     = cacheSa_q;
            sb_d     = cacheSb_q;
            prod_d   = cacheProd_q;
            result_d = (op_i == OP_MUL) ? cacheProd_q[XLEN-1:0] : cacheProd_q[2*XLEN-1:XLEN];
            state_d  = S_DONE;
          end
`endif
        end
      end
      S_CALC: begin
        hi_d  = stepSum[SW-1:BPC];
        lo_d  = {stepSum[BPC-1:0], lo_q[XLEN-1:BPC]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        result_d = selected;
        state_d  = S_DONE;
`ifdef MULT_FUSE_EN
        prod_d = product;
`endif
      end
      S_DONE: begin
        if (out_ready_i) begin
          state_d = S_IDLE;
`ifdef MULT_FUSE_EN
          if (!flush_i) begin
            cacheValid_d = 1'b1;
            cacheA_d     = aExt_q[XLEN-1:0];
            cacheB_d     = opB_q;
            cacheSa_d    = sa_q;
            cacheSb_d    = sb_q;
            cacheProd_d  = prod_q;
          end
`endif
        end
      end
    endcase
    if (flush_i) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      aExt_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      bNeg_q   <= 1'b0;
      op_q     <= '0;
      tag_q    <= '0;
      result_q <= '0;
`ifdef MULT_FUSE_EN
      opB_q        <= '0;
      sa_q         <= 1'b0;
      sb_q         <= 1'b0;
      prod_q       <= '0;
      cacheValid_q <= 1'b0;
      cacheA_q     <= '0;
      cacheB_q     <= '0;
      cacheSa_q    <= 1'b0;
      cacheSb_q    <= 1'b0;
      cacheProd_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      aExt_q   <= aExt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      bNeg_q   <= bNeg_d;
      op_q     <= op_d;
      tag_q    <= tag_d;
      result_q <= result_d;
`ifdef MULT_FUSE_EN
      opB_q        <= opB_d;
      sa_q         <= sa_d;
      sb_q         <= sb_d;
      prod_q       <= prod_d;
      cacheValid_q <= cacheValid_d;
      cacheA_q     <= cacheA_d;
      cacheB_q     <= cacheB_d;
      cacheSa_q    <= cacheSa_d;
      cacheSb_q    <= cacheSb_d;
      cacheProd_q  <= cacheProd_d;
`endif
    end
  end

  assign in_ready_o  = (state_q == S_IDLE);
  assign out_valid_o = (state_q == S_DONE);
  assign busy_o      = (state_q != S_IDLE);
  assign result_o    = result_q;
  assign tag_o       = tag_q;

endmodule

// File: tb/tb_mult_iter_param.sv
// tb_mult_iter_param: directed self-checking bench for mult_iter_param (XLEN=32, BITS_PER_CYCLE=4, TAG_W=5).
// Expected latency of the fused MUL depends on whether MULT_FUSE_EN is defined for the build.
module tb_mult_iter_param;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;

`ifdef MULT_FUSE_EN
  localparam int FUSED_LAT = 1;
`else
  localparam int FUSED_LAT = 10;
`endif

  logic        clk;
  logic        reset;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [1:0]  op_i;
  logic [31:0] operand_a_i;
  logic [31:0] operand_b_i;
  logic [4:0]  tag_i;
  logic        flush_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] result_o;
  logic [4:0]  tag_o;
  logic        busy_o;

  int passCount  = 0;
  int checkCount = 0;

  mult_iter_param #(.XLEN(32), .BITS_PER_CYCLE(4), .TAG_W(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .op_i        (op_i),
    .operand_a_i (operand_a_i),
    .operand_b_i (operand_b_i),
    .tag_i       (tag_i),
    .flush_i     (flush_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .result_o    (result_o),
    .tag_o       (tag_o),
    .busy_o      (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", name, observed, expected);
  endtask

  // Presents one request at a negedge, lets the next posedge accept it, then scrambles the ports.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] tag);
    op_i        = op;
    operand_a_i = a;
    operand_b_i = b;
    tag_i       = tag;
    in_valid_i  = 1'b1;
    @(negedge clk);
    in_valid_i  = 1'b0;
    op_i        = ~op;
    operand_a_i = ~a;
    operand_b_i = b ^ 32'h5A5A_A5A5;
    tag_i       = ~tag;
  endtask

  // Counts cycles from accept; returns -1 if out_valid_o never rises within the budget.
  task automatic waitResult(output int lat);
    lat = 1;
    while (!out_valid_o && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid_o) lat = -1;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10] = '{
    '{OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  32'h0000_0000},
    '{OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFF},
    '{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFE},
    '{OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'h0000_0001},
    '{OP_MULH,   32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000},
    '{OP_MULHU,  32'h8000_0000, 32'h8000_0000, 5'd7,  32'h4000_0000},
    '{OP_MULHU,  32'hFFFF_FFFF, 32'h0000_0002, 5'd8,  32'h0000_0001},
    '{OP_MULHSU, 32'h0000_0002, 32'hFFFF_FFFF, 5'd10, 32'h0000_0001},
    '{OP_MULH,   32'h0000_0002, 32'hFFFF_FFFF, 5'd11, 32'hFFFF_FFFF},
    '{OP_MUL,    32'hFFFF_FFFE, 32'h0000_0003, 5'd12, 32'hFFFF_FFFA}
  };

  initial begin
    int lat;
    int rises;
    reset       = 1'b1;
    in_valid_i  = 1'b0;
    op_i        = '0;
    operand_a_i = '0;
    operand_b_i = '0;
    tag_i       = '0;
    flush_i     = 1'b0;
    out_ready_i = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready", in_ready_o, 1);
    checkOutput("rst_out_valid", out_valid_o, 0);
    checkOutput("rst_result", result_o, 0);
    checkOutput("rst_tag", tag_o, 0);
    checkOutput("rst_busy", busy_o, 0);
    reset = 1'b0;
    @(negedge clk);

    // MUL 7*6 with exact latency
    applyStimulus(OP_MUL, 32'd7, 32'd6, 5'd3);
    checkOutput("mul_busy", busy_o, 1);
    checkOutput("mul_in_ready", in_ready_o, 0);
    waitResult(lat);
    checkOutput("mul_lat", lat, 10);
    checkOutput("mul_result", result_o, 32'h0000_002A);
    checkOutput("mul_tag", tag_o, 3);
    @(negedge clk);
    checkOutput("mul_idle", in_ready_o, 1);

    // Sign-extension corner vectors
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
      waitResult(lat);
      checkOutput($sformatf("vec%0d_valid", i), out_valid_o, 1);
      checkOutput($sformatf("vec%0d_result", i), result_o, vecs[i].exp);
      checkOutput($sformatf("vec%0d_tag", i), tag_o, vecs[i].tag);
      @(negedge clk);
    end

    // Backpressure in DONE with a competing request
    out_ready_i = 1'b0;
    applyStimulus(OP_MUL, 32'h0000_1234, 32'h0000_0010, 5'd9);
    waitResult(lat);
    checkOutput("bp_lat", lat, 10);
    op_i        = OP_MULHU;
    operand_a_i = 32'hDEAD_BEEF;
    operand_b_i = 32'h1111_2222;
    tag_i       = 5'd30;
    in_valid_i  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput($sformatf("bp%0d_valid", c), out_valid_o, 1);
      checkOutput($sformatf("bp%0d_result", c), result_o, 32'h0001_2340);
      checkOutput($sformatf("bp%0d_tag", c), tag_o, 9);
      checkOutput($sformatf("bp%0d_in_ready", c), in_ready_o, 0);
    end
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_idle", in_ready_o, 1);
    checkOutput("bp_no_accept", busy_o, 0);

    // Flush on the third CALC cycle
    applyStimulus(OP_MUL, 32'd9, 32'd9, 5'd13);
    repeat (2) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    checkOutput("flush_in_ready", in_ready_o, 1);
    checkOutput("flush_busy", busy_o, 0);
    rises = 0;
    for (int c = 0; c < 15; c++) begin
      if (out_valid_o) rises++;
      @(negedge clk);
    end
    checkOutput("flush_no_valid", rises, 0);
    applyStimulus(OP_MUL, 32'd3, 32'd5, 5'd14);
    waitResult(lat);
    checkOutput("post_flush_lat", lat, 10);
    checkOutput("post_flush_result", result_o, 32'h0000_000F);
    checkOutput("post_flush_tag", tag_o, 14);
    @(negedge clk);

    // Flush coinciding with an accept drops the request
    op_i        = OP_MUL;
    operand_a_i = 32'd2;
    operand_b_i = 32'd2;
    tag_i       = 5'd15;
    in_valid_i  = 1'b1;
    flush_i     = 1'b1;
    @(negedge clk);
    in_valid_i  = 1'b0;
    flush_i     = 1'b0;
    checkOutput("flush_accept_idle", in_ready_o, 1);
    checkOutput("flush_accept_busy", busy_o, 0);

    // Asynchronous reset during CALC
    applyStimulus(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd16);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("midrst_in_ready", in_ready_o, 1);
    checkOutput("midrst_out_valid", out_valid_o, 0);
    checkOutput("midrst_busy", busy_o, 0);
    checkOutput("midrst_result", result_o, 0);
    checkOutput("midrst_tag", tag_o, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // MULH then MUL on identical operands (fusion candidate)
    applyStimulus(OP_MULH, 32'h0001_0000, 32'h0003_0005, 5'd17);
    waitResult(lat);
    checkOutput("fuse_mulh_lat", lat, 10);
    checkOutput("fuse_mulh_result", result_o, 32'h0000_0003);
    checkOutput("fuse_mulh_tag", tag_o, 17);
    @(negedge clk);
    applyStimulus(OP_MUL, 32'h0001_0000, 32'h0003_0005, 5'd18);
    waitResult(lat);
    checkOutput("fuse_mul_lat", lat, FUSED_LAT);
    checkOutput("fuse_mul_result", result_o, 32'h0005_0000);
    checkOutput("fuse_mul_tag", tag_o, 18);
    @(negedge clk);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
